// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver with make/break/E0 decode into held key levels
module ps2_key_decoder #(
    parameter int          TIMEOUT    = 100000,
    parameter logic [7:0]  SC_LV1     = 8'h16,
    parameter logic [7:0]  SC_LV2     = 8'h1E,
    parameter logic [7:0]  SC_LV3     = 8'h26,
    parameter logic [7:0]  SC_CHGDIFF = 8'h23,
    parameter logic [7:0]  SC_MID     = 8'h29,
    parameter logic [7:0]  SC_UP      = 8'h75,
    parameter logic [7:0]  SC_DOWN    = 8'h72,
    parameter logic [7:0]  SC_LEFT    = 8'h6B,
    parameter logic [7:0]  SC_RIGHT   = 8'h74
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_pressed,
    output logic       btn_lv1,
    output logic       btn_lv2,
    output logic       btn_lv3,
    output logic       btn_chgdiff,
    output logic       btn_mid,
    output logic       btn_up,
    output logic       btn_down,
    output logic       btn_left,
    output logic       btn_right,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_dat_s1, r_dat_s2;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic             r_parity;
    logic [WDW-1:0]   r_wdog;
    logic             r_ext, r_brk;
    logic [8:0]       r_held;
    logic [7:0]       r_scan_code;
    logic             r_code_valid, r_frame_err;
    logic             w_fall, w_timeout, w_good;
    logic [8:0]       w_hit;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_wdog == WDW'(TIMEOUT - 1));
    assign w_good    = r_dat_s2 && (^{r_shift, r_parity});

    // Menu keys only match unprefixed, arrows only match after E0
    assign w_hit[0] = !r_ext && (r_shift == SC_LV1);
    assign w_hit[1] = !r_ext && (r_shift == SC_LV2);
    assign w_hit[2] = !r_ext && (r_shift == SC_LV3);
    assign w_hit[3] = !r_ext && (r_shift == SC_CHGDIFF);
    assign w_hit[4] = !r_ext && (r_shift == SC_MID);
    assign w_hit[5] =  r_ext && (r_shift == SC_UP);
    assign w_hit[6] =  r_ext && (r_shift == SC_DOWN);
    assign w_hit[7] =  r_ext && (r_shift == SC_LEFT);
    assign w_hit[8] =  r_ext && (r_shift == SC_RIGHT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_next = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1     <= 1'b0;
            r_clk_s2     <= 1'b0;
            r_clk_prev   <= 1'b0;
            r_dat_s1     <= 1'b0;
            r_dat_s2     <= 1'b0;
            r_shift      <= 8'h00;
            r_bitcnt     <= 3'd0;
            r_parity     <= 1'b0;
            r_wdog       <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_held       <= 9'h000;
            r_scan_code  <= 8'h00;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_clk_prev   <= r_clk_s2;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            if (r_state == S_IDLE || w_fall) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_timeout) begin
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bitcnt <= 3'd0;
                    S_DATA: begin
                        r_shift[r_bitcnt] <= r_dat_s2;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_parity <= r_dat_s2;
                    S_STOP: begin
                        if (w_good) begin
                            r_scan_code  <= r_shift;
                            r_code_valid <= 1'b1;
                            if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_held <= (r_held & ~w_hit) | (r_brk ? 9'h000 : w_hit);
                                r_ext  <= 1'b0;
                                r_brk  <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign btn_lv1     = r_held[0];
    assign btn_lv2     = r_held[1];
    assign btn_lv3     = r_held[2];
    assign btn_chgdiff = r_held[3];
    assign btn_mid     = r_held[4];
    assign btn_up      = r_held[5];
    assign btn_down    = r_held[6];
    assign btn_left    = r_held[7];
    assign btn_right   = r_held[8];
    assign key_pressed = |r_held;
    assign scan_code   = r_scan_code;
    assign code_valid  = r_code_valid;
    assign frame_err   = r_frame_err;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames and decodes make, break and extended (E0) scan codes.
- Maintains a "held" level for each game/menu key.
- Directly upstream of the menu/button controller: supplies the aggregate key_pressed and the per-key button levels (LV1/LV2/LV3/CHGDIFF/MID).
- Also supplies arrow levels to the gameplay stage.

Parameters:
- TIMEOUT, 100000, clk cycles with no PS/2 falling edge before an in-progress frame is abandoned (2 ms at 50 MHz).
- SC_LV1, 8'h16, scan code for level 1 key ('1').
- SC_LV2, 8'h1E, scan code for level 2 key ('2').
- SC_LV3, 8'h26, scan code for level 3 key ('3').
- SC_CHGDIFF, 8'h23, scan code for difficulty toggle ('D').
- SC_MID, 8'h29, scan code for mode/confirm (space).
- SC_UP / SC_DOWN / SC_LEFT / SC_RIGHT, 8'h75 / 8'h72 / 8'h6B / 8'h74, arrow codes; valid only when E0-prefixed.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- key_pressed  out  1  OR of all nine held bits
- btn_lv1, btn_lv2, btn_lv3, btn_chgdiff, btn_mid  out  1 each  held levels, menu keys
- btn_up, btn_down, btn_left, btn_right  out  1 each  held levels, E0 arrows
- scan_code  out  8  last successfully received byte
- code_valid  out  1  one-cycle pulse per good byte
- frame_err  out  1  one-cycle pulse per rejected or abandoned frame

Behaviour:
- Reset (rst=0, async):
  - all held bits, scan_code, code_valid, frame_err, ext/brk flags, shift register, bit counter and watchdog cleared to 0;
  - FSM goes to IDLE.
  - Held bits are only changed by decoded events, so key_pressed=0 during and after reset.
  - Reset mid-frame discards the partial frame; there is no output glitch on release.
- Input synchronisation:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - A third register on clk gives a falling-edge strobe: fall = prev & ~sync.
  - Data is sampled from synced ps2_data in the fall cycle.
- Frame FSM, 11-bit frame (start, 8 data LSB first, odd parity, stop). States IDLE, DATA, PARITY, STOP:
  - IDLE: on fall with data=0, go to DATA and set bitcnt=0. A fall with data=1 is ignored and stays in IDLE.
  - DATA: each fall shifts data in at bit[bitcnt]. After the 8th bit go to PARITY.
  - PARITY: latch the bit, go to STOP.
  - STOP: on fall, the frame is good iff stop=1 and XOR(data, parity)=1.
    - Good: scan_code<=byte, code_valid=1 for the next cycle, decode step runs on the same edge.
    - Bad: frame_err=1 for one cycle, byte discarded, ext/brk flags unchanged.
    - Both cases return to IDLE.
- Watchdog:
  - Counts clk cycles in any non-IDLE state; cleared on every fall.
  - On reaching TIMEOUT: return to IDLE, pulse frame_err, held bits untouched.
- Decode step, on each good byte:
  - 8'hE0: set ext.
  - 8'hF0: set brk.
  - Any other byte X is a key event:
    - mapped key = match X against the SC_* set (arrows require ext=1; menu keys require ext=0);
    - on a mapped key, held bit <= ~brk;
    - unmapped codes change nothing;
    - ext and brk are cleared after every key event, mapped or not.
  - Typematic repeat makes re-set an already-set bit (no change).
  - A break for a key not held leaves it 0.
- Latency:
  - Held bits and key_pressed change on the same edge code_valid rises.
  - That edge is the cycle after the stop-bit fall strobe.
  - Worst case 4 clk from the pin edge.
- Independence: keys are independent, and key_pressed stays 1 while any held bit is 1.
- No output toward the keyboard; ps2_clk/ps2_data are never driven.

Test Plan:
- Frame 0x16, parity 0, stop 1 -> code_valid pulse, scan_code=8'h16, btn_lv1=1, key_pressed=1; other buttons 0.
- Frames F0, 16 -> code_valid twice; after the second, btn_lv1=0, key_pressed=0; ext/brk flags cleared (follow with 0x29 -> btn_mid=1).
- E0,75 -> btn_up=1. E0,F0,75 -> btn_up=0. Plain 0x75 (no E0) -> no held change, scan_code=8'h75.
- Frame 0x16 with parity 1 -> frame_err one cycle, no code_valid, btn_lv1 unchanged. Stop=0 case gives the same result.
- Send start + 4 bits, then idle > TIMEOUT cycles -> frame_err pulse, FSM IDLE; a following good 0x1E -> btn_lv2=1.
- Hold LV1 and MID, release LV1 -> key_pressed remains 1, btn_mid=1. Assert rst=0 mid-frame -> all outputs 0 immediately; after release, the next good frame decodes correctly.
